// File: rtl/pll_lock_sequencer_pkg.sv
// Shared state encoding, default parameter values and counter sizing helper
// for the PLL lock sequencer.
`timescale 1ns/1ps
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    READY,
    FAIL
  } pll_seq_state_t;

  localparam int RST_CYCLES_DEF    = 16;
  localparam int LOCK_TIMEOUT_DEF  = 4096;
  localparam int STABLE_CYCLES_DEF = 256;
  localparam int MAX_RETRY_DEF     = 3;
  localparam int CNT_W_DEF         = 8;

  // Width able to hold 0..max_val; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, reset to 0.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  (* ASYNC_REG = "TRUE" *) logic meta_p0;
  (* ASYNC_REG = "TRUE" *) logic sync_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Drives PLL reset/power-down, waits for a stable lock before raising ready, retries on
// timeout or lock loss. Define PLL_SEQ_RELOCK_CNT_EN to build the relock event counter.
`timescale 1ns/1ps
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_CYCLES    = RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT  = LOCK_TIMEOUT_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int MAX_RETRY     = MAX_RETRY_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             restart,
  input  logic             clr_status,
  output logic             pll_rst,
  output logic             pll_pwrdwn,
  output logic             ready,
  output logic             fault,
  output logic             lock_lost,
  output logic [CNT_W-1:0] relock_cnt
);

  localparam int RST_W = cnt_width(RST_CYCLES);
  localparam int TMO_W = cnt_width(LOCK_TIMEOUT);
  localparam int STB_W = cnt_width(STABLE_CYCLES);
  localparam int RTY_W = cnt_width(MAX_RETRY);

  pll_seq_state_t   state, state_nxt;
  logic [RST_W-1:0] rst_cnt, rst_cnt_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [STB_W-1:0] stb_cnt, stb_cnt_nxt;
  logic [RTY_W-1:0] rty_cnt, rty_cnt_nxt;
  logic             lock_s;
  logic             lost_evt;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    tmo_cnt_nxt = tmo_cnt;
    stb_cnt_nxt = stb_cnt;
    rty_cnt_nxt = rty_cnt;
    lost_evt    = 1'b0;
    if (restart) begin
      state_nxt   = RESET_PLL;
      rst_cnt_nxt = '0;
      tmo_cnt_nxt = '0;
      stb_cnt_nxt = '0;
      rty_cnt_nxt = '0;
    end else begin
      case (state)
        RESET_PLL: begin
          if (rst_cnt == RST_W'(RST_CYCLES - 1)) begin
            state_nxt   = WAIT_LOCK;
            rst_cnt_nxt = '0;
          end else begin
            rst_cnt_nxt = rst_cnt + RST_W'(1);
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_nxt   = STABLE;
            stb_cnt_nxt = '0;
          end else if (tmo_cnt == TMO_W'(LOCK_TIMEOUT - 1)) begin
            if (rty_cnt == RTY_W'(MAX_RETRY)) begin
              state_nxt = FAIL;
            end else begin
              state_nxt   = RESET_PLL;
              rty_cnt_nxt = rty_cnt + RTY_W'(1);
              rst_cnt_nxt = '0;
              tmo_cnt_nxt = '0;
              stb_cnt_nxt = '0;
            end
          end else begin
            tmo_cnt_nxt = tmo_cnt + TMO_W'(1);
          end
        end
        STABLE: begin
          // A dropout returns to WAIT_LOCK with the timeout budget still partly spent.
          if (!lock_s) begin
            state_nxt = WAIT_LOCK;
          end else if (stb_cnt == STB_W'(STABLE_CYCLES - 1)) begin
            state_nxt   = READY;
            rty_cnt_nxt = '0;
          end else begin
            stb_cnt_nxt = stb_cnt + STB_W'(1);
          end
        end
        READY: begin
          if (!lock_s) begin
            lost_evt    = 1'b1;
            state_nxt   = RESET_PLL;
            rst_cnt_nxt = '0;
            tmo_cnt_nxt = '0;
            stb_cnt_nxt = '0;
          end
        end
        FAIL: begin
          state_nxt = FAIL;
        end
        default: begin
          state_nxt = RESET_PLL;
        end
      endcase
    end
  end

  // Outputs are registered copies decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RESET_PLL;
      rst_cnt    <= '0;
      tmo_cnt    <= '0;
      stb_cnt    <= '0;
      rty_cnt    <= '0;
      pll_rst    <= 1'b1;
      pll_pwrdwn <= 1'b0;
      ready      <= 1'b0;
      fault      <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      state      <= state_nxt;
      rst_cnt    <= rst_cnt_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      stb_cnt    <= stb_cnt_nxt;
      rty_cnt    <= rty_cnt_nxt;
      pll_rst    <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
      pll_pwrdwn <= (state_nxt == FAIL);
      ready      <= (state_nxt == READY);
      fault      <= (state_nxt == FAIL);
      if (lost_evt) begin
        lock_lost <= 1'b1;
      end else if (clr_status) begin
        lock_lost <= 1'b0;
      end
    end
  end

`ifdef PLL_SEQ_RELOCK_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A lock loss coinciding with a clear restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      relock_cnt <= '0;
    end else if (lost_evt) begin
      relock_cnt <= clr_status ? CNT_W'(1) : sat_inc(relock_cnt);
    end else if (clr_status) begin
      relock_cnt <= '0;
    end
  end
`else
  assign relock_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Randomised bench for pll_lock_sequencer: a PLL emulator drives the lock input and a
// phase-level reference model predicts every output each cycle.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

  localparam int TB_RST    = 16;
  localparam int TB_TMO    = 4096;
  localparam int TB_STABLE = 256;
  localparam int TB_RETRY  = 3;
  localparam int TB_CNT_W  = 2;
`ifdef PLL_SEQ_RELOCK_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int P_RESET  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_READY  = 3;
  localparam int P_GIVEUP = 4;

  logic clk, rst, pll_locked, restart, clr_status;
  logic pll_rst, pll_pwrdwn, ready, fault, lock_lost;
  logic [TB_CNT_W-1:0] relock_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // PLL emulator and stimulus controls
  int since_rel  = 0;
  int lock_delay = 100;
  int drop_cnt   = 0;
  int glitch_at  = -1;
  bit never_lock = 1'b0;
  bit rst_req    = 1'b1;

  // Reference model state
  int m_phase, m_in_phase, m_waited, m_run, m_tries, m_relock;
  bit m_lost, m_h1, m_h2;

  pll_lock_sequencer #(
    .RST_CYCLES   (TB_RST),
    .LOCK_TIMEOUT (TB_TMO),
    .STABLE_CYCLES(TB_STABLE),
    .MAX_RETRY    (TB_RETRY),
    .CNT_W        (TB_CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .restart    (restart),
    .clr_status (clr_status),
    .pll_rst    (pll_rst),
    .pll_pwrdwn (pll_pwrdwn),
    .ready      (ready),
    .fault      (fault),
    .lock_lost  (lock_lost),
    .relock_cnt (relock_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = P_RESET; m_in_phase = 0; m_waited = 0; m_run = 0; m_tries = 0;
    m_relock = 0; m_lost = 1'b0; m_h1 = 1'b0; m_h2 = 1'b0;
  endtask

  // Advance the model across one clock edge with the inputs applied before that edge.
  task automatic model_step(input bit locked_in, input bit rs, input bit cs);
    bit lk, evt;
    lk = m_h2;              // lock as sampled two edges earlier
    m_h2 = m_h1;
    m_h1 = locked_in;
    evt = 1'b0;
    if (rs) begin
      m_phase = P_RESET; m_in_phase = 0; m_waited = 0; m_run = 0; m_tries = 0;
    end else begin
      case (m_phase)
        P_RESET: begin
          m_in_phase++;
          if (m_in_phase == TB_RST) begin m_phase = P_WAIT; m_waited = 0; end
        end
        P_WAIT: begin
          if (lk) begin
            m_phase = P_STABLE; m_run = 0;
          end else begin
            m_waited++;
            if (m_waited == TB_TMO) begin
              if (m_tries == TB_RETRY) m_phase = P_GIVEUP;
              else begin m_tries++; m_phase = P_RESET; m_in_phase = 0; m_waited = 0; end
            end
          end
        end
        P_STABLE: begin
          if (!lk) m_phase = P_WAIT;
          else begin
            m_run++;
            if (m_run == TB_STABLE) begin m_phase = P_READY; m_tries = 0; end
          end
        end
        P_READY: begin
          if (!lk) begin evt = 1'b1; m_phase = P_RESET; m_in_phase = 0; m_waited = 0; end
        end
        default: ;
      endcase
    end
    if (evt) begin
      m_lost = 1'b1;
      m_relock = cs ? 1 : ((m_relock + 1 > (1 << TB_CNT_W) - 1) ? m_relock : m_relock + 1);
    end else if (cs) begin
      m_lost = 1'b0; m_relock = 0;
    end
  endtask

  function automatic logic [6:0] exp_vec();
    logic [TB_CNT_W-1:0] rc;
    rc = CNT_EN ? TB_CNT_W'(m_relock) : '0;
    return {(m_phase == P_RESET) || (m_phase == P_GIVEUP), m_phase == P_GIVEUP,
            m_phase == P_READY, m_phase == P_GIVEUP, m_lost, rc};
  endfunction

  task automatic tick(input bit rs, input bit cs);
    bit lk;
    @(negedge clk);
    if (pll_rst) since_rel = 0; else since_rel++;
    check("outs", {pll_rst, pll_pwrdwn, ready, fault, lock_lost, relock_cnt}, exp_vec());
    lk = !never_lock && !pll_rst && (since_rel >= lock_delay) && (drop_cnt == 0) &&
         (since_rel != glitch_at);
    if (drop_cnt > 0) drop_cnt--;
    rst = rst_req; pll_locked = lk; restart = rs; clr_status = cs;
    if (rst) model_reset(); else model_step(lk, rs, cs);
  endtask

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    while (!ready && n < budget) begin tick(1'b0, 1'b0); n++; end
    check("ready_rise", ready, 1'b1);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_pll_rst"}, pll_rst, 1'b1);
    check({pfx, "_pwrdwn"}, pll_pwrdwn, 1'b0);
    check({pfx, "_ready"}, ready, 1'b0);
    check({pfx, "_fault"}, fault, 1'b0);
    check({pfx, "_lock_lost"}, lock_lost, 1'b0);
    check({pfx, "_relock"}, relock_cnt, 0);
  endtask

  initial begin
    int n, g;
    rst = 1'b1; pll_locked = 1'b0; restart = 1'b0; clr_status = 1'b0;
    model_reset();
    @(posedge clk);
    repeat (3) tick(1'b0, 1'b0);
    check_reset_values("por");

    // Power-up: reset hold length and lock-to-ready latency
    rst_req = 1'b0;
    tick(1'b0, 1'b0);
    n = 0;
    while (pll_rst && n < 100) begin tick(1'b0, 1'b0); n++; end
    check("rst_hold", n, TB_RST);
    wait_ready(2000);
    check("lock_to_ready", since_rel, lock_delay + 3 + TB_STABLE);

    // Lock dropout of five cycles while ready
    lock_delay = $urandom_range(20, 200);
    drop_cnt = 5;
    repeat (3) tick(1'b0, 1'b0);
    check("ready_hold", ready, 1'b1);
    tick(1'b0, 1'b0);
    check("loss_ready", ready, 1'b0);
    check("loss_pll_rst", pll_rst, 1'b1);
    check("loss_sticky", lock_lost, 1'b1);
    check("loss_cnt1", relock_cnt, CNT_EN ? 1 : 0);
    wait_ready(3000);

    // Four more losses saturate the 2-bit counter
    repeat (4) begin
      lock_delay = $urandom_range(10, 200);
      drop_cnt = $urandom_range(1, 6);
      n = 0;
      while (ready && n < 20) begin tick(1'b0, 1'b0); n++; end
      check("ready_fall", ready, 1'b0);
      wait_ready(3000);
    end
    check("relock_sat", relock_cnt, CNT_EN ? 3 : 0);

    // Clear coinciding with a lock loss: the set wins
    drop_cnt = 3;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("clr_coinc_lost", lock_lost, 1'b1);
    check("clr_coinc_cnt", relock_cnt, CNT_EN ? 1 : 0);
    wait_ready(3000);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    check("clr_lost", lock_lost, 1'b0);
    check("clr_cnt", relock_cnt, 0);

    // PLL never locks: four full attempts, then give up
    never_lock = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n = 0;
    while (!fault && n < 20000) begin tick(1'b0, 1'b0); n++; end
    check("fail_time", n, (TB_RETRY + 1) * (TB_RST + TB_TMO));
    check("fail_fault", fault, 1'b1);
    check("fail_pwrdwn", pll_pwrdwn, 1'b1);
    check("fail_pll_rst", pll_rst, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("restart_fault", fault, 1'b0);
    check("restart_pll_rst", pll_rst, 1'b1);
    check("restart_pwrdwn", pll_pwrdwn, 1'b0);
    check("restart_keep_lost", lock_lost, 1'b0);
    never_lock = 1'b0;
    lock_delay = $urandom_range(20, 300);
    wait_ready(3000);

    // Single-cycle lock glitch about 200 cycles into STABLE
    lock_delay = $urandom_range(50, 300);
    g = lock_delay + 200;
    glitch_at = g;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    wait_ready(3000);
    check("glitch_lat", since_rel, g + 4 + TB_STABLE);
    glitch_at = -1;

    // Random dropouts, clears and restarts
    lock_delay = $urandom_range(10, 150);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 199) == 0) drop_cnt = $urandom_range(1, 6);
      tick($urandom_range(0, 799) == 0, $urandom_range(0, 149) == 0);
    end

    // Asynchronous reset while waiting for lock
    lock_delay = 1000;
    tick(1'b1, 1'b0);
    repeat (40) tick(1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1; rst_req = 1'b1;
    model_reset();
    #1;
    check_reset_values("async_rst");
    repeat (2) tick(1'b0, 1'b0);
    lock_delay = 50;
    rst_req = 1'b0;
    tick(1'b0, 1'b0);
    wait_ready(3000);
    tick(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
